neuron_mac: RTL and testbench

//  Streaming multiply-accumulate neuron stage directly upstream of the tanh activation block.

---
 rtl/nn_fx_pkg.sv | 35 +++
 rtl/neuron_mac_if.sv | 24 ++
 rtl/fx_mul_scale.sv | 29 ++
 rtl/neuron_mac.sv | 122 ++++++++++++
 tb/tb_neuron_mac.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/nn_fx_pkg.sv
// Shared decimal fixed-point definitions (1.0 == 10**8) for the neuron MAC and tanh stages.
package nn_fx_pkg;

    localparam int FX_W = 32;
    localparam int FX_ACC_W = 64;
    localparam logic signed [63:0] FX_SCALE = 64'sd100000000;

    typedef logic signed [FX_W-1:0] fx_t;

    localparam fx_t FX_MAX = 32'h7FFFFFFF;
    localparam fx_t FX_MIN = 32'h80000000;

    localparam logic signed [63:0] FX_SAT_HI = 64'sd2147483647;
    localparam logic signed [63:0] FX_SAT_LO = -64'sd2147483648;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } mac_state_e;

    // Clamp a 64-bit accumulator onto the 32-bit encodings tanh treats as +/- full scale.
    function automatic fx_t fx_sat32(input logic signed [63:0] acc);
        fx_t res;
        if (acc > FX_SAT_HI) begin
            res = FX_MAX;
        end else if (acc < FX_SAT_LO) begin
            res = FX_MIN;
        end else begin
            res = acc[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Input-pair stream, result stream and status for the neuron MAC stage.
interface neuron_mac_if #(
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_x;
    logic signed [DATA_W-1:0] in_w;
    logic signed [DATA_W-1:0] in_bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;

    modport master (
        output in_valid, in_x, in_w, in_bias, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_x, in_w, in_bias, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fx_mul_scale.sv
// Combinational fixed-point product: full-width x*w, then divided by the unit scale
// with truncation toward zero.
module fx_mul_scale
    import nn_fx_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                ACC_W  = 64,
    parameter logic signed [63:0] SCALE = FX_SCALE
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  term
);

    localparam logic signed [ACC_W-1:0] SCALE_S = ACC_W'(SCALE);

    logic signed [ACC_W-1:0] x_ext_s;
    logic signed [ACC_W-1:0] w_ext_s;
    logic signed [ACC_W-1:0] prod_s;

    // Signed operands on both sides keep the division signed, so it truncates toward zero.
    always_comb begin
        x_ext_s = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
        w_ext_s = {{(ACC_W-DATA_W){w[DATA_W-1]}}, w};
        prod_s  = x_ext_s * w_ext_s;
        term    = prod_s / SCALE_S;
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming neuron pre-activation: bias + sum of scaled x*w over N_INPUTS beats,
// saturated to 32 bits and held until the tanh stage takes it.
module neuron_mac
    import nn_fx_pkg::*;
#(
    parameter int                 N_INPUTS = 8,
    parameter int                 DATA_W   = 32,
    parameter int                 ACC_W    = 64,
    parameter logic signed [63:0] SCALE    = FX_SCALE
) (
    input  logic        clk,
    input  logic        rst_n,
    neuron_mac_if.slave bus
);

    localparam int              CNT_W    = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam bit              SINGLE   = (N_INPUTS == 1);

    mac_state_e              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    fx_t                     out_data_q, out_data_d;

    logic signed [ACC_W-1:0] term_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic                    beat_s;

    fx_mul_scale #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SCALE  (SCALE)
    ) u_mul (
        .x    (bus.in_x),
        .w    (bus.in_w),
        .term (term_s)
    );

    assign bus.in_ready  = (state_q != OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign beat_s     = bus.in_valid && (state_q != OUT);
    assign bias_ext_s = {{(ACC_W-DATA_W){bus.in_bias[DATA_W-1]}}, bus.in_bias};

    // Next-state, accumulator and output-register computation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (beat_s) begin
                    acc_d   = bias_ext_s + term_s;
                    count_d = CNT_ONE;
                    if (SINGLE) begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = fx_sat32(64'(acc_d));
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (beat_s) begin
                    acc_d   = acc_q + term_s;
                    count_d = count_q + CNT_ONE;
                    // Result is captured on entry to OUT so it is stable for the whole handshake.
                    if (count_q == CNT_LAST) begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = fx_sat32(64'(acc_d));
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    count_d     = '0;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d     = IDLE;
                count_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'sd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: an N_INPUTS=4 instance for the main scenarios and an
// N_INPUTS=1 instance for the single-beat variant.
module tb_neuron_mac;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   results4;
    int   results1;

    neuron_mac_if #(.DATA_W(32)) bus4 ();
    neuron_mac_if #(.DATA_W(32)) bus1 ();

    neuron_mac #(.N_INPUTS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    neuron_mac #(.N_INPUTS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count completed result handshakes on each instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            results4 <= 0;
            results1 <= 0;
        end else begin
            if (bus4.out_valid && bus4.out_ready) results4 <= results4 + 1;
            if (bus1.out_valid && bus1.out_ready) results1 <= results1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one pair at a negedge and return at the negedge after it was accepted.
    task automatic send4(input logic signed [31:0] x, input logic signed [31:0] w,
                         input logic signed [31:0] b);
        int n;
        n = 0;
        bus4.in_valid = 1'b1;
        bus4.in_x     = x;
        bus4.in_w     = w;
        bus4.in_bias  = b;
        while (bus4.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait4", {31'd0, bus4.in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send1(input logic signed [31:0] x, input logic signed [31:0] w,
                         input logic signed [31:0] b);
        int n;
        n = 0;
        bus1.in_valid = 1'b1;
        bus1.in_x     = x;
        bus1.in_w     = w;
        bus1.in_bias  = b;
        while (bus1.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait1", {31'd0, bus1.in_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Called right after the last beat: result must already be valid, then take it.
    task automatic finish4(input string tag, input logic [31:0] exp);
        bus4.in_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, bus4.out_valid}, 32'd1);
        chk({tag, "_data"}, bus4.out_data, exp);
        chk({tag, "_busy"}, {31'd0, bus4.busy}, 32'd1);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        chk({tag, "_valid_clr"}, {31'd0, bus4.out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus4.busy}, 32'd0);
    endtask

    initial begin
        int r0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_x = 32'sd0; bus4.in_w = 32'sd0; bus4.in_bias = 32'sd0;
        bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_x = 32'sd0; bus1.in_w = 32'sd0; bus1.in_bias = 32'sd0;
        bus1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, bus4.out_valid}, 32'd0);
        chk("rst_data", bus4.out_data, 32'd0);
        chk("rst_busy", {31'd0, bus4.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);

        // 1: basic; bias on later beats must be ignored
        for (int i = 0; i < 4; i++)
            send4(32'sd100000000, 32'sd50000000, (i == 0) ? 32'sd0 : 32'sd999);
        finish4("t1", 32'sd200000000);

        // 2: bias, sign, truncation toward zero
        send4(-32'sd3, 32'sd50000000, -32'sd100000000);
        send4(32'sd100000000, -32'sd25000000, 32'sd0);
        send4(32'sd0, 32'sd7, 32'sd0);
        send4(32'sd0, 32'sd7, 32'sd0);
        finish4("t2", -32'sd125000001);

        // 3: saturation both ways
        for (int i = 0; i < 4; i++) send4(32'sd2000000000, 32'sd2000000000, 32'sd0);
        finish4("t3_pos", 32'h7FFFFFFF);
        for (int i = 0; i < 4; i++) send4(-32'sd2000000000, 32'sd2000000000, 32'sd0);
        finish4("t3_neg", 32'h80000000);

        // 4: input stall then output backpressure
        r0 = results4;
        send4(32'sd300000000, 32'sd100000000, 32'sd7);
        send4(32'sd300000000, 32'sd100000000, 32'sd0);
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_busy", {31'd0, bus4.busy}, 32'd1);
            chk("t4_stall_valid", {31'd0, bus4.out_valid}, 32'd0);
        end
        send4(32'sd300000000, 32'sd100000000, 32'sd0);
        send4(32'sd300000000, 32'sd100000000, 32'sd0);
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'd0, bus4.out_valid}, 32'd1);
            chk("t4_hold_data", bus4.out_data, 32'sd1200000007);
            chk("t4_hold_in_ready", {31'd0, bus4.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        finish4("t4", 32'sd1200000007);
        repeat (2) @(negedge clk);
        chk("t4_single", results4 - r0, 32'd1);

        // 5: reset mid-evaluation discards the partial sum
        send4(32'sd500000000, 32'sd100000000, 32'sd0);
        send4(32'sd500000000, 32'sd100000000, 32'sd0);
        bus4.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", {31'd0, bus4.busy}, 32'd0);
        chk("t5_rst_data", bus4.out_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) send4(32'sd100000000, 32'sd100000000, 32'sd0);
        finish4("t5", 32'sd400000000);

        // 6: back-to-back with in_valid held high and out_ready high
        r0 = results4;
        bus4.out_ready = 1'b1;
        send4(32'sd100000000, 32'sd100000000, 32'sd5);
        for (int i = 0; i < 3; i++) send4(32'sd100000000, 32'sd100000000, 32'sd0);
        chk("t6a_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("t6a_data", bus4.out_data, 32'sd400000005);
        chk("t6a_in_ready", {31'd0, bus4.in_ready}, 32'd0);
        send4(32'sd200000000, 32'sd100000000, -32'sd5);
        for (int i = 0; i < 3; i++) send4(32'sd200000000, 32'sd100000000, 32'sd0);
        chk("t6b_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("t6b_data", bus4.out_data, 32'sd799999995);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_done", {31'd0, bus4.out_valid}, 32'd0);
        chk("t6_count", results4 - r0, 32'd2);
        bus4.out_ready = 1'b0;

        // 6b: N_INPUTS=1, result after every beat
        bus1.out_ready = 1'b1;
        send1(32'sd100000000, 32'sd200000000, 32'sd5);
        chk("n1a_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("n1a_data", bus1.out_data, 32'sd200000005);
        send1(-32'sd100000000, 32'sd100000000, -32'sd5);
        chk("n1b_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("n1b_data", bus1.out_data, -32'sd100000005);
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("n1_done", {31'd0, bus1.out_valid}, 32'd0);
        chk("n1_count", results1, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
